tic_tac_toe_comp_player: RTL and testbench
==========================================

// Module: tic_tac_toe_comp_player
// PURPOSE
// Computer opponent for the tic-tac-toe game core. Reads the nine board cells and the game status.
// Selects a legal computer move by sequential line scanning: win, then block, then preference order.
// Drives comp_pos with a one-cycle pc strobe into the game core, then waits for the core to confirm the move.
// Sits between the game core's board outputs and its comp_pos/pc move inputs.
// PARAMETERS
// TIMEOUT_CYC  16     cycles to wait in WAIT_ACK for the cell to show COMP before giving up
// CNT_W        5      width of timeout counter; must hold TIMEOUT_CYC
// COMP_CODE    2'b10  cell encoding of a computer mark (player = 2'b01, empty = 2'b00)
// PORTS
// clk        in   1  system clock, rising edge
// reset      in   1  asynchronous, active-low reset (0 = reset)
// req        in   1  level/pulse: computer's turn; sampled only in IDLE
// pos1..pos9 in   2  board cells, index 0..8 = pos1..pos9; 00 empty, 01 player, 10 computer
// who        in   2  game status: 00 in progress, 01 player won, 10 computer won, 11 draw
// comp_pos   out  4  chosen cell index 0..8, held from ISSUE until next accepted req
// pc         out  1  one-cycle move strobe to game core, high only in ISSUE
// busy       out  1  high in every state except IDLE
// done       out  1  one-cycle pulse: core confirmed move (cell == COMP_CODE)
// no_move    out  1  one-cycle pulse: req refused (who != 00 or board full)
// timeout    out  1  one-cycle pulse: WAIT_ACK expired without confirmation
// BEHAVIOUR
// - Reset (reset=0): state=IDLE; comp_pos=0, pc=0, busy=0, done=0, no_move=0, timeout=0; counters=0.
// - Reset is honoured in any state; an in-flight move is abandoned and pc is never issued.
// - All outputs are registered.
// - States: IDLE, SCAN_WIN, SCAN_BLOCK, PICK, ISSUE, WAIT_ACK, REFUSE.
// - IDLE: on req=1 with who!=00 or no empty cell -> REFUSE (no_move=1 next cycle) -> IDLE.
// - IDLE: otherwise, snapshot all 9 cells, set line_idx=0, go to SCAN_WIN.
// - Board snapshot is used for all decisions; live pos inputs are read only in WAIT_ACK.
// - Line order, idx 0..7: (0,1,2) (3,4,5) (6,7,8) (0,3,6) (1,4,7) (2,5,8) (0,4,8) (2,4,6).
// - SCAN_WIN: one line per cycle.
//   - Hit = exactly two cells COMP and one empty. On a hit, comp_pos = the empty cell -> ISSUE.
//   - No hit on idx 7 -> SCAN_BLOCK, idx=0.
// - SCAN_BLOCK: same scan, but hit = two cells PLAYER and one empty. No hit on idx 7 -> PICK.
// - The first hit in line order wins. Lower line index has priority.
// - PICK: one cycle. Choose the first empty cell in the order 4, 0, 2, 6, 8, 1, 3, 5, 7 -> ISSUE.
// - Latency, req accepted in cycle N:
//   - Win on line k: pc in cycle N+2+k.
//   - Block on line k: pc in cycle N+10+k.
//   - Fallback: pc in cycle N+18.
// - ISSUE: pc=1 for exactly one cycle, with comp_pos valid in the same cycle -> WAIT_ACK, timer=0.
// - WAIT_ACK: each cycle, check the live cell at comp_pos.
//   - Cell == COMP_CODE -> done=1 next cycle, IDLE.
//   - Else timer++. When timer reaches TIMEOUT_CYC-1 -> timeout=1 next cycle, IDLE.
//   - Confirm and expiry in the same cycle: confirm wins.
// - req while busy: ignored, not queued.
// - done, no_move and timeout are mutually exclusive. Each is a single-cycle pulse.
// TESTING
// - Reset: hold reset=0 with req=1 for 5 cycles -> all outputs 0, busy=0, pc never asserted.
// - Win: board pos1=pos2=10, pos3=00, pos4=pos5=01, rest empty, who=00, req at N.
//   -> pc=1 at N+2, comp_pos=2. Model writes cell 2 = 10 -> done pulse, then busy=0.
// - Block: pos1=pos2=01, pos5=10, rest empty, req at N -> no win; block line 0 hits.
//   -> pc at N+10, comp_pos=2.
// - Fallback: empty board, req at N -> pc at N+18, comp_pos=4.
//   - Same with pos5=01 -> comp_pos=0.
// - Refuse: who=01 with req -> no_move pulse, pc stays 0.
//   - Full draw board with who=00 -> no_move pulse.
// - Timeout/abort: model never writes the cell -> timeout pulse TIMEOUT_CYC cycles after pc.
//   - reset=0 during SCAN_BLOCK -> IDLE, pc never asserted.

Source files
------------

// File: rtl/tic_tac_toe_comp_player.sv
// Computer opponent for the tic-tac-toe game core.
// It takes a snapshot of the board and scans the eight lines one per cycle,
// first for a winning move and then for a blocking move. If neither exists it
// takes the first empty cell in a fixed preference order. It then strobes pc
// with comp_pos and waits for the core to show the computer mark in that cell.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// S_IDLE       | waiting for req; an illegal req is refused, a legal one takes a snapshot
// S_SCAN_WIN   | line line_idx_q: two computer marks plus one empty cell -> take it
// S_SCAN_BLOCK | line line_idx_q: two player marks plus one empty cell -> take it
// S_PICK       | fallback: first empty cell in order 4,0,2,6,8,1,3,5,7
// S_ISSUE      | pc high for one cycle, comp_pos valid
// S_WAIT_ACK   | watch the live cell at comp_pos until it is COMP or the timer expires
// S_REFUSE     | no_move pulse, then back to idle
module tic_tac_toe_comp_player #(
    parameter int         TIMEOUT_CYC = 16,
    parameter int         CNT_W       = 5,
    parameter logic [1:0] COMP_CODE   = 2'b10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    input  logic [1:0] who,
    output logic [3:0] comp_pos,
    output logic       pc,
    output logic       busy,
    output logic       done,
    output logic       no_move,
    output logic       timeout
);

    localparam logic [1:0]       PLAYER_CODE = 2'b01;
    localparam logic [1:0]       EMPTY_CODE  = 2'b00;
    localparam logic [CNT_W-1:0] TIMER_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       PICK_ORDER [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8,
                                                    4'd1, 4'd3, 4'd5, 4'd7};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN_WIN,
        S_SCAN_BLOCK,
        S_PICK,
        S_ISSUE,
        S_WAIT_ACK,
        S_REFUSE
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             line_idx_q, line_idx_d;
    logic [CNT_W-1:0]       timer_q, timer_d;
    logic [8:0][1:0]        board_q, board_d;
    logic [3:0]             comp_pos_q, comp_pos_d;
    logic                   pc_q, pc_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   no_move_q, no_move_d;
    logic                   timeout_q, timeout_d;

    logic [8:0][1:0]        board_live;
    logic                   any_empty_live;
    logic [3:0]             cell_a, cell_b, cell_c;
    logic [1:0]             val_a, val_b, val_c;
    logic [1:0]             mark;
    logic                   hit;
    logic [3:0]             hit_cell;
    logic [3:0]             pick_cell;
    logic                   confirm;
    logic                   expire;
    logic [CNT_W-1:0]       timer_inc;

    // Cell indices {a, b, c} of each scan line, in priority order.
    function automatic logic [11:0] line_cells(input logic [2:0] idx);
        case (idx)
            3'd0:    return {4'd0, 4'd1, 4'd2};
            3'd1:    return {4'd3, 4'd4, 4'd5};
            3'd2:    return {4'd6, 4'd7, 4'd8};
            3'd3:    return {4'd0, 4'd3, 4'd6};
            3'd4:    return {4'd1, 4'd4, 4'd7};
            3'd5:    return {4'd2, 4'd5, 4'd8};
            3'd6:    return {4'd0, 4'd4, 4'd8};
            default: return {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    // Live board view and emptiness check used at request time.
    always_comb begin
        board_live     = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
        any_empty_live = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (board_live[i] == EMPTY_CODE) any_empty_live = 1'b1;
        end
    end

    // Evaluate the current scan line against the snapshot; the mark depends on the scan phase.
    always_comb begin
        {cell_a, cell_b, cell_c} = line_cells(line_idx_q);
        val_a    = board_q[cell_a];
        val_b    = board_q[cell_b];
        val_c    = board_q[cell_c];
        mark     = (state_q == S_SCAN_BLOCK) ? PLAYER_CODE : COMP_CODE;
        hit      = 1'b0;
        hit_cell = cell_a;
        if (val_a == EMPTY_CODE && val_b == mark && val_c == mark) begin
            hit      = 1'b1;
            hit_cell = cell_a;
        end else if (val_a == mark && val_b == EMPTY_CODE && val_c == mark) begin
            hit      = 1'b1;
            hit_cell = cell_b;
        end else if (val_a == mark && val_b == mark && val_c == EMPTY_CODE) begin
            hit      = 1'b1;
            hit_cell = cell_c;
        end
    end

    // Fallback choice: walk the preference list backwards so the earliest empty entry wins.
    always_comb begin
        pick_cell = 4'd4;
        for (int i = 8; i >= 0; i--) begin
            if (board_q[PICK_ORDER[i]] == EMPTY_CODE) pick_cell = PICK_ORDER[i];
        end
    end

    // Acknowledge watch on the live board; confirmation takes priority over expiry.
    always_comb begin
        confirm   = (board_live[comp_pos_q] == COMP_CODE);
        timer_inc = timer_q + CNT_W'(1);
        expire    = (timer_inc == TIMER_LAST);
    end

    // State and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            line_idx_q <= '0;
            timer_q    <= '0;
            board_q    <= '0;
            comp_pos_q <= '0;
            pc_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            no_move_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_idx_q <= line_idx_d;
            timer_q    <= timer_d;
            board_q    <= board_d;
            comp_pos_q <= comp_pos_d;
            pc_q       <= pc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            no_move_q  <= no_move_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic, including scan index, timer and board snapshot.
    always_comb begin
        state_d    = state_q;
        line_idx_d = line_idx_q;
        timer_d    = timer_q;
        board_d    = board_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (who != 2'b00 || !any_empty_live) begin
                        state_d = S_REFUSE;
                    end else begin
                        board_d    = board_live;
                        line_idx_d = '0;
                        state_d    = S_SCAN_WIN;
                    end
                end
            end
            S_SCAN_WIN: begin
                if (hit) begin
                    state_d = S_ISSUE;
                end else if (line_idx_q == 3'd7) begin
                    line_idx_d = '0;
                    state_d    = S_SCAN_BLOCK;
                end else begin
                    line_idx_d = line_idx_q + 3'd1;
                end
            end
            S_SCAN_BLOCK: begin
                if (hit) begin
                    state_d = S_ISSUE;
                end else if (line_idx_q == 3'd7) begin
                    state_d = S_PICK;
                end else begin
                    line_idx_d = line_idx_q + 3'd1;
                end
            end
            S_PICK:  state_d = S_ISSUE;
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (confirm || expire) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_REFUSE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: values the output flops take on the next edge.
    always_comb begin
        comp_pos_d = comp_pos_q;
        if ((state_q == S_SCAN_WIN || state_q == S_SCAN_BLOCK) && hit) begin
            comp_pos_d = hit_cell;
        end else if (state_q == S_PICK) begin
            comp_pos_d = pick_cell;
        end
        pc_d      = (state_d == S_ISSUE);
        busy_d    = (state_d != S_IDLE);
        no_move_d = (state_d == S_REFUSE);
        done_d    = (state_q == S_WAIT_ACK) && confirm;
        timeout_d = (state_q == S_WAIT_ACK) && !confirm && expire;
    end

    assign comp_pos = comp_pos_q;
    assign pc       = pc_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign no_move  = no_move_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_tic_tac_toe_comp_player.sv
// Directed bench for tic_tac_toe_comp_player: reset, win/block/fallback
// latency and cell choice, refusal, acknowledge timeout and mid-scan reset.
`timescale 1ns/1ps
module tb_tic_tac_toe_comp_player;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [1:0] who;
    logic [1:0] cells [9];
    logic [3:0] comp_pos;
    logic       pc, busy, done, no_move, timeout;

    int vectors = 0;
    int errors  = 0;

    tic_tac_toe_comp_player #(
        .TIMEOUT_CYC(16),
        .CNT_W      (5),
        .COMP_CODE  (2'b10)
    ) dut (
        .clk     (clk),
        .reset   (rst_n),
        .req     (req),
        .pos1    (cells[0]),
        .pos2    (cells[1]),
        .pos3    (cells[2]),
        .pos4    (cells[3]),
        .pos5    (cells[4]),
        .pos6    (cells[5]),
        .pos7    (cells[6]),
        .pos8    (cells[7]),
        .pos9    (cells[8]),
        .who     (who),
        .comp_pos(comp_pos),
        .pc      (pc),
        .busy    (busy),
        .done    (done),
        .no_move (no_move),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 9; i++) cells[i] = 2'b00;
        who = 2'b00;
    endtask

    // Issue req, measure cycles until pc, then either confirm the move like
    // the game core would or let the acknowledge window expire.
    task automatic run_move(input string tag, input int exp_lat,
                            input logic [3:0] exp_pos, input bit write_cell);
        int n;
        req = 1'b1;
        step();
        req = 1'b0;
        n = 1;
        while (pc !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_pc_latency"}, n, exp_lat);
        chk({tag, "_comp_pos"}, comp_pos, exp_pos);
        chk({tag, "_busy_at_pc"}, busy, 1);
        step();
        chk({tag, "_pc_one_cycle"}, pc, 0);
        if (write_cell) begin
            if (comp_pos < 4'd9) cells[comp_pos] = 2'b10;
            step();
            chk({tag, "_done"}, done, 1);
            chk({tag, "_busy_after_done"}, busy, 0);
            chk({tag, "_no_timeout"}, timeout, 0);
            step();
            chk({tag, "_done_pulse"}, done, 0);
        end else begin
            n = 1;
            while (timeout !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            chk({tag, "_timeout_latency"}, n, 16);
            chk({tag, "_busy_after_timeout"}, busy, 0);
            chk({tag, "_no_done"}, done, 0);
            step();
            chk({tag, "_timeout_pulse"}, timeout, 0);
        end
    endtask

    initial begin
        bit pc_seen;
        rst_n = 1'b0;
        req   = 1'b1;
        clear_board();

        // Reset held with req asserted
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_pc", pc, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_no_move", no_move, 0);
            chk("rst_timeout", timeout, 0);
            chk("rst_comp_pos", comp_pos, 0);
        end
        req   = 1'b0;
        rst_n = 1'b1;
        step();
        step();

        // Win on line 0: cell 2
        clear_board();
        cells[0] = 2'b10; cells[1] = 2'b10; cells[3] = 2'b01; cells[4] = 2'b01;
        run_move("win_l0", 2, 4'd2, 1'b1);

        // Win on line 6 (0,4,8): cell 8
        clear_board();
        cells[0] = 2'b10; cells[4] = 2'b10; cells[1] = 2'b01; cells[3] = 2'b01;
        run_move("win_l6", 8, 4'd8, 1'b1);

        // Block on line 0: cell 2
        clear_board();
        cells[0] = 2'b01; cells[1] = 2'b01; cells[4] = 2'b10;
        run_move("block_l0", 10, 4'd2, 1'b1);

        // Block on line 2 (6,7,8): cell 8
        clear_board();
        cells[6] = 2'b01; cells[7] = 2'b01; cells[4] = 2'b10;
        run_move("block_l2", 12, 4'd8, 1'b1);

        // Fallback on empty board: centre
        clear_board();
        run_move("pick_empty", 18, 4'd4, 1'b1);

        // Fallback with centre taken: corner 0
        clear_board();
        cells[4] = 2'b01;
        run_move("pick_corner", 18, 4'd0, 1'b1);

        // Refuse: game already decided
        clear_board();
        who = 2'b01;
        req = 1'b1;
        step();
        req = 1'b0;
        chk("refuse_who_no_move", no_move, 1);
        chk("refuse_who_busy", busy, 1);
        chk("refuse_who_pc", pc, 0);
        step();
        chk("refuse_who_pulse", no_move, 0);
        chk("refuse_who_idle", busy, 0);
        chk("refuse_who_pc2", pc, 0);

        // Refuse: full board, game still marked in progress
        clear_board();
        cells[0] = 2'b01; cells[1] = 2'b10; cells[2] = 2'b01;
        cells[3] = 2'b01; cells[4] = 2'b10; cells[5] = 2'b10;
        cells[6] = 2'b10; cells[7] = 2'b01; cells[8] = 2'b01;
        req = 1'b1;
        step();
        req = 1'b0;
        chk("refuse_full_no_move", no_move, 1);
        chk("refuse_full_pc", pc, 0);
        step();
        chk("refuse_full_pulse", no_move, 0);
        chk("refuse_full_done", done, 0);

        // Acknowledge never arrives
        clear_board();
        cells[0] = 2'b10; cells[1] = 2'b10;
        run_move("timeout", 2, 4'd2, 1'b0);

        // Reset during block scan abandons the move
        clear_board();
        req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("abort_busy_in_scan", busy, 1);
        chk("abort_pc_in_scan", pc, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy_async", busy, 0);
        step();
        rst_n = 1'b1;
        pc_seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (pc === 1'b1) pc_seen = 1'b1;
        end
        chk("abort_pc_never", pc_seen, 0);
        chk("abort_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
